button_debounce: RTL and testbench

- Input-side counterpart to the board LED driver: reads the on-board push-buttons (async, bouncing pins) into clean per-button level and event signals.
- Per channel: 2-flop synchroniser, debounce counter, then press/release/long-press pulse generation in the sys_clk domain.
- Consumers are LED/mode-control logic that need exactly one pulse per physical press.

---
 rtl/button_debounce.sv | 259 +++++++++++++++++++++++++
 tb/tb_button_debounce.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Turns raw, bouncing push-button pins into clean per-button level and event
// signals in the sys_clk domain. Each channel is fully independent:
//
//   pin -> 2-flop synchroniser -> polarity normalise -> debounce counter
//       -> btn_level -> press/release edge pulses
//                    -> hold state machine -> long-press pulse
//                                          -> (optional) auto-repeat presses
//
// Ports
//   sys_clk      in   1      system clock, rising edge
//   sys_rst      in   1      asynchronous, active-high reset
//   btn_in       in   N_BTN  raw button pins, asynchronous to sys_clk
//   btn_level    out  N_BTN  debounced state, 1 = pressed (any pin polarity)
//   btn_press    out  N_BTN  1-cycle pulse when a press is accepted
//   btn_release  out  N_BTN  1-cycle pulse when a release is accepted
//   btn_long     out  N_BTN  1-cycle pulse once per hold, LONG_CYC cycles
//                            after btn_press
//
// Build option
//   BUTTON_DEBOUNCE_REPEAT_EN  when defined, a button held past the long-press
//                              point re-issues btn_press every RPT_CYC cycles.
//                              When undefined no repeat logic exists and
//                              REPEAT_MS has no effect.
//
// Timing (DB_CYC = CLK_HZ/1000*DEBOUNCE_MS, LONG_CYC = CLK_HZ/1000*LONG_MS)
//   A clean pin edge shows up on btn_level DB_CYC+2 cycles later: two cycles
//   of synchroniser, then DB_CYC consecutive cycles of disagreement.
//   The event pulses are registered alongside btn_level, so btn_press and
//   btn_release are high in the first cycle btn_level shows the new value.
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int CLK_HZ      = 27000000,
  parameter int N_BTN       = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  // -------------------------------------------------------------------------
  // Derived cycle counts and counter widths
  // -------------------------------------------------------------------------
  localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;

  // Counters only ever reach (count - 1); the +1 keeps the width at least one
  // bit even for DB_CYC = 1, and nothing ever wraps.
  localparam int DB_W   = $clog2(DB_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int RPT_CYC = CLK_HZ / 1000 * REPEAT_MS;
  localparam int RPT_W   = $clog2(RPT_CYC + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_CYC - 1);
`endif

  // Value the synchroniser holds while the button is released; loading this
  // at reset means a pin already pressed at reset release is seen as a fresh
  // press rather than being silently absorbed.
  localparam logic SYNC_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Hold state machine encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_LONGHELD = 2'd2;

  // Reject configurations where the long press could fire before (or at the
  // same time as) the debounced press itself.
  generate
    if (DB_CYC < 1 || LONG_CYC <= DB_CYC) begin : g_bad_cfg
      $error("button_debounce: configuration needs DB_CYC >= 1 and LONG_CYC > DB_CYC");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Per-channel datapath
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan

      // Synchroniser
      logic sync1_q, sync1_d;
      logic sync2_q, sync2_d;
      logic pressed_s;

      // Debounce
      logic [DB_W-1:0] db_cnt_q, db_cnt_d;
      logic            level_q, level_d;

      // Events
      logic press_q, press_d;
      logic release_q, release_d;
      logic long_q, long_d;

      // Hold tracking
      logic [1:0]        state_q, state_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

      // Extra press pulse from auto-repeat (constant 0 without the option)
      logic rpt_fire;

      // ---------------------------------------------------------------------
      // Synchroniser: plain two-stage shift of the raw pin.
      // ---------------------------------------------------------------------
      always_comb begin
        sync1_d = btn_in[gi];
        sync2_d = sync1_q;
      end

      // Normalise polarity only after the second flop so both flops see the
      // raw pin and nothing combinational sits in the metastability path.
      assign pressed_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

      // ---------------------------------------------------------------------
      // Debounce: count consecutive cycles where the synchronised input
      // disagrees with the accepted level. Any agreeing cycle restarts the
      // count, so only an uninterrupted run of DB_CYC cycles flips the level.
      // ---------------------------------------------------------------------
      always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (pressed_s != level_q) begin
          if (db_cnt_q == DB_LAST) begin
            level_d = pressed_s;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
      end

      // ---------------------------------------------------------------------
      // Hold state machine. It looks at level_d so that its state lines up
      // with level_q cycle for cycle, and so that a release arriving on the
      // very cycle the long press would fire suppresses that pulse.
      // ---------------------------------------------------------------------
      always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        if (!level_d) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              // level_q is 0 here, so level_d = 1 is the press edge
              state_d    = ST_HOLD;
              hold_cnt_d = '0;
            end
            ST_HOLD: begin
              if (hold_cnt_q == HOLD_LAST) begin
                long_d  = 1'b1;
                state_d = ST_LONGHELD;
              end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
              end
            end
            ST_LONGHELD: begin
              // counter frozen; one long pulse per hold
            end
            default: begin
              state_d    = ST_IDLE;
              hold_cnt_d = '0;
            end
          endcase
        end
      end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      // ---------------------------------------------------------------------
      // Auto-repeat: runs only while in LONGHELD and still pressed. The
      // counter starts from 0 on the cycle btn_long fires, so the first
      // repeat lands RPT_CYC cycles after btn_long and then every RPT_CYC.
      // ---------------------------------------------------------------------
      logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

      always_comb begin
        rpt_cnt_d = '0;
        rpt_fire  = 1'b0;
        if (level_d && (state_q == ST_LONGHELD)) begin
          if (rpt_cnt_q == RPT_LAST) begin
            rpt_fire = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          rpt_cnt_q <= '0;
        end else begin
          rpt_cnt_q <= rpt_cnt_d;
        end
      end
`else
      assign rpt_fire = 1'b0;
`endif

      // ---------------------------------------------------------------------
      // Edge events. A press and a release cannot coincide: a release needs
      // level_d = 0, while both press sources need level_d = 1.
      // ---------------------------------------------------------------------
      always_comb begin
        press_d   = (level_d & ~level_q) | rpt_fire;
        release_d = level_q & ~level_d;
      end

      // ---------------------------------------------------------------------
      // State registers
      // ---------------------------------------------------------------------
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          sync1_q    <= SYNC_RELEASED;
          sync2_q    <= SYNC_RELEASED;
          db_cnt_q   <= '0;
          level_q    <= 1'b0;
          press_q    <= 1'b0;
          release_q  <= 1'b0;
          long_q     <= 1'b0;
          state_q    <= ST_IDLE;
          hold_cnt_q <= '0;
        end else begin
          sync1_q    <= sync1_d;
          sync2_q    <= sync2_d;
          db_cnt_q   <= db_cnt_d;
          level_q    <= level_d;
          press_q    <= press_d;
          release_q  <= release_d;
          long_q     <= long_d;
          state_q    <= state_d;
          hold_cnt_q <= hold_cnt_d;
        end
      end

      assign btn_level[gi]   = level_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
      assign btn_long[gi]    = long_q;

    end
  endgenerate

endmodule

// File: tb/tb_button_debounce.sv
`timescale 1ns/1ps
module tb_button_debounce;

  localparam int N_BTN    = 2;
  localparam int DB_CYC   = 4;
  localparam int LONG_CYC = 20;
  localparam int RPT_CYC  = 5;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [N_BTN-1:0] btn_in  = '1;
  logic [N_BTN-1:0] btn_level, btn_press, btn_release, btn_long;

  int checks   = 0;
  int failures = 0;
  int now      = 0;

  // Behavioural reference: pin history through two delay slots, a run-length
  // of disagreement, and timestamps of the last accepted press.
  logic [N_BTN-1:0] m_sh1, m_sh2, m_lvl, m_press, m_rel, m_long;
  int               m_run    [N_BTN];
  int               m_tpress [N_BTN];

  button_debounce #(
    .CLK_HZ      (1000),
    .N_BTN       (N_BTN),
    .ACTIVE_LOW  (1),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20),
    .REPEAT_MS   (5)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_sh1   = '1;
    m_sh2   = '1;
    m_lvl   = '0;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int c = 0; c < N_BTN; c++) begin
      m_run[c]    = 0;
      m_tpress[c] = -100000;
    end
  endtask

  // One clock: advance the reference on the edge, then return 1 ns later.
  task automatic tick();
    logic s, old;
    int   age;
    @(posedge sys_clk);
    now++;
    if (sys_rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < N_BTN; c++) begin
        s   = ~m_sh2[c];
        old = m_lvl[c];
        if (s != old) begin
          m_run[c]++;
          if (m_run[c] >= DB_CYC) begin
            m_lvl[c] = s;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_press[c] = m_lvl[c] & ~old;
        m_rel[c]   = old & ~m_lvl[c];
        if (m_press[c]) m_tpress[c] = now;
        age        = now - m_tpress[c];
        m_long[c]  = m_lvl[c] && (age == LONG_CYC);
        if (RPT_ON && m_lvl[c] && age > LONG_CYC && ((age - LONG_CYC) % RPT_CYC) == 0)
          m_press[c] = 1'b1;
        m_sh2[c] = m_sh1[c];
        m_sh1[c] = btn_in[c];
      end
    end
    #1;
  endtask

  task automatic wait_press(input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      tick();
      if (btn_press[ch]) at = now;
    end
  endtask

  task automatic wait_release(input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      tick();
      if (btn_release[ch]) at = now;
    end
  endtask

  task automatic settle();
    btn_in = '1;
    repeat (15) tick();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    btn_in  = '1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== '0) begin
        failures++;
        $display("FAIL reset_hold: outputs=%b required=0", {btn_level, btn_press, btn_release, btn_long});
      end
    end
    sys_rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== '0) begin
        failures++;
        $display("FAIL reset_idle: cycle %0d outputs=%b required=0", now, {btn_level, btn_press, btn_release, btn_long});
      end
    end
    $display("test_reset: 3 reset cycles and 50 idle cycles observed");
  endtask

  task automatic test_clean_press();
    int t, p, r;
    t = now;
    btn_in[0] = 1'b0;
    p = -1;
    for (int k = 0; k < 20 && p < 0; k++) begin
      tick();
      checks++;
      if ({btn_level[1], btn_press[1], btn_release[1], btn_long[1]} !== 4'b0) begin
        failures++;
        $display("FAIL ch1_quiet: ch1 outputs=%b required=0000", {btn_level[1], btn_press[1], btn_release[1], btn_long[1]});
      end
      if (btn_press[0]) p = now;
    end
    checks++;
    if (p < 0 || (p - t) != DB_CYC + 2) begin
      failures++;
      $display("FAIL press_latency: got %0d required %0d", (p < 0) ? -1 : p - t, DB_CYC + 2);
    end
    checks++;
    if (btn_level[0] !== 1'b1) begin
      failures++;
      $display("FAIL press_level: level=%b required 1", btn_level[0]);
    end
    tick();
    checks++;
    if (btn_press[0] !== 1'b0) begin
      failures++;
      $display("FAIL press_width: press=%b one cycle after pulse, required 0", btn_press[0]);
    end
    r = now;
    btn_in[0] = 1'b1;
    wait_release(0, 20, p);
    checks++;
    if (p < 0 || (p - r) != DB_CYC + 2) begin
      failures++;
      $display("FAIL release_latency: got %0d required %0d", (p < 0) ? -1 : p - r, DB_CYC + 2);
    end
    checks++;
    if (btn_level[0] !== 1'b0 || btn_press[0] !== 1'b0) begin
      failures++;
      $display("FAIL release_level: level=%b press=%b required 0 0", btn_level[0], btn_press[0]);
    end
    tick();
    checks++;
    if (btn_release[0] !== 1'b0) begin
      failures++;
      $display("FAIL release_width: release=%b required 0", btn_release[0]);
    end
    $display("test_clean_press: press at %0d (pin %0d), release seen at %0d (pin %0d)", now, t, p, r);
    settle();
  endtask

  task automatic test_bounce();
    int lows [3] = '{3, 2, 3};
    int s, p;
    for (int i = 0; i < 3; i++) begin
      btn_in[0] = 1'b0;
      for (int k = 0; k <= lows[i]; k++) begin
        if (k == lows[i]) btn_in[0] = 1'b1;
        tick();
        checks++;
        if ({btn_level[0], btn_press[0], btn_release[0]} !== 3'b0) begin
          failures++;
          $display("FAIL bounce_reject: cycle %0d level/press/release=%b required 000", now, {btn_level[0], btn_press[0], btn_release[0]});
        end
      end
    end
    s = now;
    btn_in[0] = 1'b0;
    wait_press(0, 20, p);
    checks++;
    if (p < 0 || (p - s) != DB_CYC + 2) begin
      failures++;
      $display("FAIL bounce_then_press: latency %0d required %0d", (p < 0) ? -1 : p - s, DB_CYC + 2);
    end
    $display("test_bounce: glitches 3/2/3 rejected, steady press at %0d", p);
    settle();
  endtask

  task automatic test_long_press();
    int p, lc, cnt, rc;
    // full hold: exactly one long pulse, LONG_CYC after the press
    btn_in[0] = 1'b0;
    wait_press(0, 20, p);
    cnt = 0;
    lc  = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (btn_long[0]) begin
        cnt++;
        lc = now;
      end
    end
    checks++;
    if (cnt != 1) begin
      failures++;
      $display("FAIL long_count: got %0d pulses required 1", cnt);
    end
    checks++;
    if (p < 0 || lc < 0 || (lc - p) != LONG_CYC) begin
      failures++;
      $display("FAIL long_delay: got %0d required %0d", (lc < 0 || p < 0) ? -1 : lc - p, LONG_CYC);
    end
    $display("test_long_press: press %0d long %0d pulses %0d", p, lc, cnt);
    settle();

    // release debounced 15 cycles after the press: no long
    btn_in[0] = 1'b0;
    wait_press(0, 20, p);
    while (p >= 0 && now < p + 9) tick();
    btn_in[0] = 1'b1;
    cnt = 0;
    rc  = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (btn_long[0]) cnt++;
      if (btn_release[0]) rc = now;
    end
    checks++;
    if (cnt != 0 || p < 0 || (rc - p) != 15) begin
      failures++;
      $display("FAIL short_hold: long pulses %0d release delay %0d required 0 and 15", cnt, rc - p);
    end
    $display("test_long_press: short hold released at %0d, long pulses %0d", rc, cnt);
    settle();

    // release lands on the exact cycle the long pulse would fire
    btn_in[0] = 1'b0;
    wait_press(0, 20, p);
    while (p >= 0 && now < p + LONG_CYC - (DB_CYC + 2)) tick();
    btn_in[0] = 1'b1;
    cnt = 0;
    rc  = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (btn_long[0]) cnt++;
      if (btn_release[0]) rc = now;
    end
    checks++;
    if (cnt != 0 || p < 0 || (rc - p) != LONG_CYC) begin
      failures++;
      $display("FAIL release_wins: long pulses %0d release delay %0d required 0 and %0d", cnt, rc - p, LONG_CYC);
    end
    $display("test_long_press: boundary release at %0d, long pulses %0d", rc, cnt);
    settle();
  endtask

  task automatic test_reset_mid_hold();
    int p, r, p2, lc;
    btn_in[0] = 1'b0;
    wait_press(0, 20, p);
    while (p >= 0 && now < p + 10) tick();
    checks++;
    if (btn_level[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_level: level=%b required 1", btn_level[0]);
    end
    sys_rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long} !== '0) begin
      failures++;
      $display("FAIL reset_immediate: outputs=%b required 0", {btn_level, btn_press, btn_release, btn_long});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== '0) begin
        failures++;
        $display("FAIL reset_quiet: outputs=%b required 0", {btn_level, btn_press, btn_release, btn_long});
      end
    end
    sys_rst = 1'b0;
    r = now;
    wait_press(0, 20, p2);
    checks++;
    if (p2 < 0 || (p2 - r) != DB_CYC + 2) begin
      failures++;
      $display("FAIL post_reset_press: delay %0d required %0d", (p2 < 0) ? -1 : p2 - r, DB_CYC + 2);
    end
    lc = -1;
    for (int k = 0; k < 30 && lc < 0; k++) begin
      tick();
      if (btn_long[0]) lc = now;
    end
    checks++;
    if (lc < 0 || p2 < 0 || (lc - p2) != LONG_CYC) begin
      failures++;
      $display("FAIL post_reset_long: delay %0d required %0d", (lc < 0 || p2 < 0) ? -1 : lc - p2, LONG_CYC);
    end
    $display("test_reset_mid_hold: new press %0d long %0d", p2, lc);
    settle();
  endtask

  task automatic test_repeat();
    int p, lc, cnt, bad, exp_cnt;
    exp_cnt = RPT_ON ? 8 : 0;
    btn_in[0] = 1'b0;
    wait_press(0, 20, p);
    lc = -1;
    for (int k = 0; k < 30 && lc < 0; k++) begin
      tick();
      if (btn_long[0]) lc = now;
    end
    checks++;
    if (lc < 0) begin
      failures++;
      $display("FAIL repeat_long: no long pulse within 30 cycles, required one");
    end
    cnt = 0;
    bad = 0;
    while (lc >= 0 && now < lc + 40) begin
      tick();
      if (btn_press[0]) begin
        cnt++;
        if (((now - lc) % RPT_CYC) != 0) bad++;
      end
    end
    checks++;
    if (cnt != exp_cnt) begin
      failures++;
      $display("FAIL repeat_count: got %0d extra presses required %0d", cnt, exp_cnt);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL repeat_phase: %0d presses off the %0d-cycle grid, required 0", bad, RPT_CYC);
    end
    $display("test_repeat: long %0d, extra presses %0d", lc, cnt);
    settle();
  endtask

  task automatic test_random();
    int remain [N_BTN];
    for (int c = 0; c < N_BTN; c++) remain[c] = 1;
    for (int k = 0; k < 815; k++) begin
      if (k < 800) begin
        for (int c = 0; c < N_BTN; c++) begin
          remain[c]--;
          if (remain[c] <= 0) begin
            btn_in[c] = ~btn_in[c];
            remain[c] = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 9);
          end
        end
      end else begin
        btn_in = '1;
      end
      tick();
      checks++;
      if (btn_level !== m_lvl) begin
        failures++;
        $display("FAIL rand_level: cycle %0d got %b required %b", now, btn_level, m_lvl);
      end
      checks++;
      if (btn_press !== m_press) begin
        failures++;
        $display("FAIL rand_press: cycle %0d got %b required %b", now, btn_press, m_press);
      end
      checks++;
      if (btn_release !== m_rel) begin
        failures++;
        $display("FAIL rand_release: cycle %0d got %b required %b", now, btn_release, m_rel);
      end
      checks++;
      if (btn_long !== m_long) begin
        failures++;
        $display("FAIL rand_long: cycle %0d got %b required %b", now, btn_long, m_long);
      end
    end
    $display("test_random: 815 cycles of random pin activity on %0d channels", N_BTN);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_reset_mid_hold();
    test_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
